// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - stage-count and segment-width helpers for csa_final_adder_pipe
package csa_pkg;

  localparam int CSA_DEF_BIT_LEN = 16;
  localparam int CSA_DEF_SEG_LEN = 8;

  function automatic int num_stg(input int bit_len, input int seg_len);
    return (bit_len + seg_len - 1) / seg_len;
  endfunction

  // Every segment is seg_len wide except the top one, which takes the remainder.
  function automatic int seg_width(input int k, input int bit_len, input int seg_len);
    int n;
    n = num_stg(bit_len, seg_len);
    return (k < n - 1) ? seg_len : bit_len - (n - 1) * seg_len;
  endfunction

endpackage

// File: rtl/csa_seg_adder.sv
// rtl/csa_seg_adder.sv - combinational W-bit segment adder with carry in/out
module csa_seg_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_final_adder_pipe.sv
// rtl/csa_final_adder_pipe.sv - segmented, pipelined carry-propagate adder for a CSA (S, C) pair
// Optional sticky overflow output enabled by CSA_FINAL_ADDER_OVF_STICKY_EN.
module csa_final_adder_pipe
  import csa_pkg::*;
#(
  parameter int BIT_LEN = CSA_DEF_BIT_LEN,
  parameter int SEG_LEN = CSA_DEF_SEG_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_s,
  input  logic [BIT_LEN-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] out_sum,
  output logic               out_cout
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
  ,
  output logic               ovf_sticky
`endif
);

  localparam int NUM_STG = num_stg(BIT_LEN, SEG_LEN);

  typedef struct packed {
    logic               valid;
    logic               carry;
    logic [BIT_LEN-1:0] s;
    logic [BIT_LEN-1:0] c;
  } stg_t;

  stg_t [NUM_STG-1:0]              stg_q;
  stg_t [NUM_STG-1:0]              src;
  logic [NUM_STG-1:0][BIT_LEN-1:0] s_d;
  logic [NUM_STG-1:0]              carry_d;
  logic [NUM_STG-1:0]              vld;
  logic [NUM_STG-1:0]              rdy;

  // Stage k's adder works on the record it is about to capture, so stage 0 adds straight from the inputs.
  assign src[0]   = {in_valid, 1'b0, in_s, in_c};
  assign in_ready = rdy[0];

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    localparam int LO = k * SEG_LEN;
    localparam int W  = seg_width(k, BIT_LEN, SEG_LEN);

    logic [W-1:0]       seg_sum;
    logic               seg_cout;
    logic [BIT_LEN-1:0] s_new;

    if (k > 0) begin : g_link
      assign src[k] = stg_q[k-1];
    end

    assign vld[k] = stg_q[k].valid;
    // Unrolled form of ready_k = !valid_k | ready_{k+1}: some stage at or after k is empty, or the sink accepts.
    assign rdy[k] = out_ready | ~(&vld[NUM_STG-1:k]);

    csa_seg_adder #(.W(W)) u_add (
      .a    (src[k].s[LO +: W]),
      .b    (src[k].c[LO +: W]),
      .cin  (src[k].carry),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      s_new           = src[k].s;
      s_new[LO +: W]  = seg_sum;
    end

    assign s_d[k]     = s_new;
    assign carry_d[k] = seg_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STG; k++) begin
        if (rdy[k]) begin
          stg_q[k].valid <= src[k].valid;
          // A bubble moves in as valid=0 while the data fields keep their last contents.
          if (src[k].valid) begin
            stg_q[k].carry <= carry_d[k];
            stg_q[k].s     <= s_d[k];
            stg_q[k].c     <= src[k].c;
          end
        end
      end
    end
  end

  assign out_valid = stg_q[NUM_STG-1].valid;
  assign out_sum   = stg_q[NUM_STG-1].s;
  assign out_cout  = stg_q[NUM_STG-1].carry;

  logic unused_c;
  assign unused_c = ^stg_q[NUM_STG-1].c;

`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = ovf_q | (out_valid & out_ready & out_cout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_csa_final_adder_pipe.sv
// tb/tb_csa_final_adder_pipe.sv - scoreboard bench for csa_final_adder_pipe (16/4 and 10/4 builds)
module tb_csa_final_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_cout;
  logic [15:0] a_in_s, a_in_c, a_out_sum;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_cout;
  logic [9:0]  b_in_s, b_in_c, b_out_sum;
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
  logic        a_ovf, b_ovf;
`endif

  csa_final_adder_pipe #(.BIT_LEN(16), .SEG_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_s(a_in_s), .in_c(a_in_c),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .out_cout(a_out_cout)
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    , .ovf_sticky(a_ovf)
`endif
  );

  csa_final_adder_pipe #(.BIT_LEN(10), .SEG_LEN(4)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_s(b_in_s), .in_c(b_in_c),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_cout(b_out_cout)
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    , .ovf_sticky(b_ovf)
`endif
  );

  typedef struct {
    logic [16:0] exp;
    int          t;
    bit          lat;
  } exp_t;

  exp_t qa[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the 17-bit arithmetic sum; low 16 bits are out_sum, bit 16 is out_cout.
  task automatic send_a(input logic [15:0] s, input logic [15:0] c, input bit lat);
    exp_t e;
    int   g;
    g = 0;
    a_in_valid = 1'b1;
    a_in_s     = s;
    a_in_c     = c;
    do begin
      @(negedge clk);
      g++;
    end while (!a_in_ready && g < 200);
    if (!a_in_ready) begin
      chk("send_timeout", 32'(a_in_ready), 32'd1);
    end else begin
      e.exp = {1'b0, s} + {1'b0, c};
      e.t   = cyc + 1;
      e.lat = lat;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_a(input int maxc);
    int g;
    g = 0;
    while (qa.size() != 0 && g < maxc) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", 32'(qa.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [9:0] s, input logic [9:0] c);
    logic [10:0] e;
    int          t;
    int          g;
    e = {1'b0, s} + {1'b0, c};
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    b_in_s     = s;
    b_in_c     = c;
    @(negedge clk);
    chk("b_in_ready", 32'(b_in_ready), 32'd1);
    t = cyc + 1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!b_out_valid && g < 20);
    chk("b_latency", 32'(cyc + 1 - t), 32'd3);
    chk("b_sum", 32'(b_out_sum), 32'(e[9:0]));
    chk("b_cout", 32'(b_out_cout), 32'(e[10]));
  endtask

  // Monitor: pops on every output transfer and checks that a stalled output holds still.
  initial begin : monitor
    exp_t        e;
    bit          stall_seen;
    logic [15:0] h_sum;
    logic        h_cout;
    stall_seen = 1'b0;
    h_sum      = '0;
    h_cout     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          chk("stall_valid", 32'(a_out_valid), 32'd1);
          chk("stall_sum", 32'(a_out_sum), 32'(h_sum));
          chk("stall_cout", 32'(a_out_cout), 32'(h_cout));
        end
        stall_seen = a_out_valid && !a_out_ready;
        h_sum      = a_out_sum;
        h_cout     = a_out_cout;
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            chk("unexpected_out", 32'(a_out_sum), 32'hDEAD_BEEF);
          end else begin
            e = qa.pop_front();
            chk("sum", 32'(a_out_sum), 32'(e.exp[15:0]));
            chk("cout", 32'(a_out_cout), 32'(e.exp[16]));
            if (e.lat) chk("latency", 32'(cyc + 1 - e.t), 32'd4);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int  ntx;
    bit  done;
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_s      = '0;
    a_in_c      = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_s      = '0;
    b_in_c      = '0;
    b_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_sum", 32'(a_out_sum), 32'd0);
    chk("rst_out_cout", 32'(a_out_cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    idle(1);

    // Carry ripples from segment 0 through segment 1.
    send_a(16'h00FF, 16'h0001, 1'b1);
    chk("no_comb_out", 32'(a_out_valid), 32'd0);
    drain_a(20);
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    chk("ovf_clear", 32'(a_ovf), 32'd0);
`endif

    // Wrap-around and sticky overflow.
    send_a(16'hFFFF, 16'h0002, 1'b1);
    drain_a(20);
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    chk("ovf_set", 32'(a_ovf), 32'd1);
`endif
    send_a(16'h0001, 16'h0001, 1'b1);
    drain_a(20);
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    chk("ovf_hold", 32'(a_ovf), 32'd1);
`endif

    // Reset with three items in flight; none of them may surface afterwards.
    send_a(16'(($urandom)), 16'h1111, 1'b0);
    send_a(16'(($urandom)), 16'h2222, 1'b0);
    send_a(16'(($urandom)), 16'h3333, 1'b0);
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_out_sum", 32'(a_out_sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
`ifdef CSA_FINAL_ADDER_OVF_STICKY_EN
    chk("ovf_after_rst", 32'(a_ovf), 32'd0);
`endif
    idle(10);

    // 100 back-to-back random pairs, each with exact 4-cycle latency.
    repeat (100) send_a(16'($urandom), 16'($urandom), 1'b1);
    drain_a(20);

    // Stall under continuous input: exactly 4 accepted, then in_ready low.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_s      = 16'($urandom);
    a_in_c      = 16'($urandom);
    ntx = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_in_ready) begin
        exp_t e;
        e.exp = {1'b0, a_in_s} + {1'b0, a_in_c};
        e.t   = cyc + 1;
        e.lat = 1'b0;
        qa.push_back(e);
        ntx++;
      end
      @(posedge clk); #1;
      a_in_s = 16'($urandom);
      a_in_c = 16'($urandom);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    chk("stall_count", 32'(ntx), 32'd4);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    // Full pipeline: a new input is taken in the cycle the head leaves.
    send_a(16'h8001, 16'h7FFF, 1'b0);
    drain_a(30);

    // Random stalls and random input gaps.
    done = 1'b0;
    fork
      begin
        repeat (150) begin
          send_a(16'($urandom), 16'($urandom), 1'b0);
          idle($urandom_range(0, 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_out_ready = 1'($urandom_range(0, 1));
        end
        a_out_ready = 1'b1;
      end
    join
    drain_a(50);

    // 10-bit build: three stages, 2-bit top segment.
    send_b(10'h3FF, 10'h001);
    repeat (6) send_b(10'($urandom), 10'($urandom));
    send_b(10'h200, 10'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
